// File: rtl/regfile_bist_driver.sv
// regfile_bist_driver
//   Built-in self-test sequencer for the register file. It takes over the
//   processor test wrapper (test = 1) and runs a two-pass march: pass 0
//   writes raw(i) = PATTERN + i*STRIDE to every register and reads it back.
//   Pass 1 does the same with ~raw(i). Reads use both ports at once, with
//   port A walking upward and port B walking downward. The first mismatch
//   ends the run and records the register number and the value observed.
//
// Ports
//   clock, reset           : system clock, asynchronous active-high reset
//   start                  : begin a run (sampled only in IDLE / DONE)
//   test                   : wrapper test-mux select, high while running
//   t_ctrl_writeEnable     : regfile write enable
//   t_ctrl_writeReg        : regfile write address
//   t_ctrl_readRegA/B      : read addresses for ports A and B
//   t_data_writeReg        : regfile write data
//   t_data_readRegA/B      : read data returned READ_LAT cycles after address
//   busy / done / pass     : run status; pass is valid while done is high
//   fail_reg / fail_data   : first failing register and the value it returned

module regfile_bist_driver #(
  parameter logic [31:0] PATTERN  = 32'hA5A5_0000,
  parameter logic [31:0] STRIDE   = 32'h0001_0001,
  parameter int          READ_LAT = 1,
  parameter bit          R0_ZERO  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        test,
  output logic        t_ctrl_writeEnable,
  output logic [4:0]  t_ctrl_writeReg,
  output logic [4:0]  t_ctrl_readRegA,
  output logic [4:0]  t_ctrl_readRegB,
  output logic [31:0] t_data_writeReg,
  input  logic [31:0] t_data_readRegA,
  input  logic [31:0] t_data_readRegB,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  fail_reg,
  output logic [31:0] fail_data
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam int LAST = READ_LAT - 1;

  state_t                     state_q, state_d;
  logic                       pass_idx_q, pass_idx_d;
  logic [4:0]                 idx_q, idx_d;
  logic                       pass_q, pass_d;
  logic [4:0]                 fail_reg_q, fail_reg_d;
  logic [31:0]                fail_data_q, fail_data_d;
  logic [READ_LAT-1:0]        pipe_vld_q, pipe_vld_d;
  logic [READ_LAT-1:0][4:0]   pipe_k_q, pipe_k_d;

  logic        cmp_vld;
  logic [4:0]  cmp_k_a;
  logic [4:0]  cmp_k_b;
  logic        mis_a;
  logic        mis_b;

  // Data written to register r in the given pass (inv = 1 for pass 1).
  function automatic logic [31:0] data_for(input logic [4:0] r, input logic inv);
    logic [31:0] raw;
    raw = PATTERN + STRIDE * {27'd0, r};
    return inv ? ~raw : raw;
  endfunction

  // Value the register should read back; r0 may be hardwired to zero.
  function automatic logic [31:0] expect_for(input logic [4:0] r, input logic inv);
    if (R0_ZERO && (r == 5'd0)) begin
      return 32'd0;
    end
    return data_for(r, inv);
  endfunction

  // The oldest pipeline stage lines up with the data currently on the ports.
  assign cmp_vld = pipe_vld_q[LAST] && ((state_q == READ) || (state_q == DRAIN));
  assign cmp_k_a = pipe_k_q[LAST];
  assign cmp_k_b = 5'd31 - pipe_k_q[LAST];
  assign mis_a   = cmp_vld && (t_data_readRegA != expect_for(cmp_k_a, pass_idx_q));
  assign mis_b   = cmp_vld && (t_data_readRegB != expect_for(cmp_k_b, pass_idx_q));

  // Next-state logic. idx counts write index, read index, or drain cycles
  // depending on the state. A mismatch discards the pipeline and ends the run.
  always_comb begin
    state_d     = state_q;
    pass_idx_d  = pass_idx_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    fail_reg_d  = fail_reg_q;
    fail_data_d = fail_data_q;
    pipe_vld_d  = '0;
    pipe_k_d    = '0;

    pipe_vld_d[0] = (state_q == READ);
    pipe_k_d[0]   = idx_q;
    for (int s = 1; s < READ_LAT; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_k_d[s]   = pipe_k_q[s-1];
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = WRITE;
          pass_idx_d  = 1'b0;
          idx_d       = 5'd0;
          pass_d      = 1'b0;
          fail_reg_d  = 5'd0;
          fail_data_d = 32'd0;
        end
      end
      WRITE: begin
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d = READ;
          idx_d   = 5'd0;
        end
      end
      READ: begin
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d = DRAIN;
          idx_d   = 5'd0;
        end
      end
      DRAIN: begin
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'(LAST)) begin
          idx_d = 5'd0;
          if (pass_idx_q == 1'b0) begin
            state_d    = WRITE;
            pass_idx_d = 1'b1;
          end else begin
            state_d = DONE;
            pass_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Port A takes priority when both ports miscompare in the same cycle.
    if (mis_a || mis_b) begin
      state_d     = DONE;
      pass_d      = 1'b0;
      idx_d       = 5'd0;
      pipe_vld_d  = '0;
      fail_reg_d  = mis_a ? cmp_k_a : cmp_k_b;
      fail_data_d = mis_a ? t_data_readRegA : t_data_readRegB;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pass_idx_q  <= 1'b0;
      idx_q       <= 5'd0;
      pass_q      <= 1'b0;
      fail_reg_q  <= 5'd0;
      fail_data_q <= 32'd0;
      pipe_vld_q  <= '0;
      pipe_k_q    <= '0;
    end else begin
      state_q     <= state_d;
      pass_idx_q  <= pass_idx_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      fail_reg_q  <= fail_reg_d;
      fail_data_q <= fail_data_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_k_q    <= pipe_k_d;
    end
  end

  assign busy               = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
  assign test               = busy;
  assign done               = (state_q == DONE);
  assign pass               = pass_q;
  assign fail_reg           = fail_reg_q;
  assign fail_data          = fail_data_q;
  assign t_ctrl_writeEnable = (state_q == WRITE);
  assign t_ctrl_writeReg    = (state_q == WRITE) ? idx_q : 5'd0;
  assign t_data_writeReg    = (state_q == WRITE) ? data_for(idx_q, pass_idx_q) : 32'd0;
  assign t_ctrl_readRegA    = (state_q == READ) ? idx_q : 5'd0;
  assign t_ctrl_readRegB    = (state_q == READ) ? (5'd31 - idx_q) : 5'd0;

endmodule

// File: tb/tb_regfile_bist_driver.sv
// Testbench for regfile_bist_driver. It uses a behavioural register file
// with one-cycle registered reads. The register file can inject a few
// faults: a stuck bit, a writable r0, and a stuck MSB in r31.

module tb_regfile_bist_driver;

  logic        clock;
  logic        reset;
  logic        start;
  logic        test;
  logic        t_ctrl_writeEnable;
  logic [4:0]  t_ctrl_writeReg;
  logic [4:0]  t_ctrl_readRegA;
  logic [4:0]  t_ctrl_readRegB;
  logic [31:0] t_data_writeReg;
  logic [31:0] t_data_readRegA;
  logic [31:0] t_data_readRegB;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  fail_reg;
  logic [31:0] fail_data;

  int errors;
  int checks;
  int faultMode;
  int cyc;

  logic [31:0] mem [32];

  regfile_bist_driver dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .test               (test),
    .t_ctrl_writeEnable (t_ctrl_writeEnable),
    .t_ctrl_writeReg    (t_ctrl_writeReg),
    .t_ctrl_readRegA    (t_ctrl_readRegA),
    .t_ctrl_readRegB    (t_ctrl_readRegB),
    .t_data_writeReg    (t_data_writeReg),
    .t_data_readRegA    (t_data_readRegA),
    .t_data_readRegB    (t_data_readRegB),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .fail_reg           (fail_reg),
    .fail_data          (fail_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Fault modes: 0 good, 1 r7 bit0 stuck-at-0, 2 r0 writable, 3 r31 bit31 stuck-at-1.
  function automatic logic [31:0] modelRead(input logic [4:0] a);
    logic [31:0] v;
    v = mem[a];
    if (a == 5'd0 && faultMode != 2) v = 32'd0;
    if (faultMode == 1 && a == 5'd7) v[0] = 1'b0;
    if (faultMode == 3 && a == 5'd31) v[31] = 1'b1;
    return v;
  endfunction

  // Register file model: synchronous write and registered read.
  always @(posedge clock) begin
    if (t_ctrl_writeEnable) mem[t_ctrl_writeReg] <= t_data_writeReg;
    t_data_readRegA <= modelRead(t_ctrl_readRegA);
    t_data_readRegB <= modelRead(t_ctrl_readRegB);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, or leave it high when hold is set.
  // On return the bench is observing the state after the start edge.
  task automatic applyStimulus(input bit hold);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    if (!hold) start = 1'b0;
  endtask

  // Count edges until done rises. Treat an expired budget as a failure.
  task automatic waitDone(input int from, output int n);
    n = from;
    while (!done && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!done) checkOutput("done_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    faultMode = 0;
    start     = 1'b0;
    reset     = 1'b1;
    for (int r = 0; r < 32; r++) mem[r] = 32'd0;
    repeat (2) @(negedge clock);

    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_test", {31'd0, test}, 32'd0);
    checkOutput("rst_pass", {31'd0, pass}, 32'd0);
    checkOutput("rst_we", {31'd0, t_ctrl_writeEnable}, 32'd0);
    checkOutput("rst_fail_data", fail_data, 32'd0);
    reset = 1'b0;

    $display("[TB] good register file run");
    applyStimulus(1'b0);
    checkOutput("run_busy", {31'd0, busy}, 32'd1);
    checkOutput("run_test", {31'd0, test}, 32'd1);
    repeat (5) @(negedge clock);
    checkOutput("wr5_we", {31'd0, t_ctrl_writeEnable}, 32'd1);
    checkOutput("wr5_addr", {27'd0, t_ctrl_writeReg}, 32'd5);
    checkOutput("wr5_data", t_data_writeReg, 32'hA5AA_0005);
    waitDone(5, cyc);
    checkOutput("good_latency", cyc, 32'd130);
    checkOutput("good_pass", {31'd0, pass}, 32'd1);
    checkOutput("good_test", {31'd0, test}, 32'd0);
    @(negedge clock);
    checkOutput("good_done_held", {31'd0, done}, 32'd1);

    $display("[TB] r7 bit0 stuck-at-0");
    faultMode = 1;
    applyStimulus(1'b0);
    checkOutput("restart_done_clr", {31'd0, done}, 32'd0);
    checkOutput("restart_pass_clr", {31'd0, pass}, 32'd0);
    waitDone(0, cyc);
    checkOutput("r7_latency", cyc, 32'd41);
    checkOutput("r7_pass", {31'd0, pass}, 32'd0);
    checkOutput("r7_fail_reg", {27'd0, fail_reg}, 32'd7);
    checkOutput("r7_fail_data", fail_data, 32'hA5AC_0006);

    $display("[TB] writable r0");
    faultMode = 2;
    applyStimulus(1'b0);
    waitDone(0, cyc);
    checkOutput("r0_latency", cyc, 32'd34);
    checkOutput("r0_pass", {31'd0, pass}, 32'd0);
    checkOutput("r0_fail_reg", {27'd0, fail_reg}, 32'd0);
    checkOutput("r0_fail_data", fail_data, 32'hA5A5_0000);

    $display("[TB] r31 bit31 stuck-at-1");
    faultMode = 3;
    applyStimulus(1'b0);
    waitDone(0, cyc);
    checkOutput("r31_latency", cyc, 32'd99);
    checkOutput("r31_pass", {31'd0, pass}, 32'd0);
    checkOutput("r31_fail_reg", {27'd0, fail_reg}, 32'd31);
    checkOutput("r31_fail_data", fail_data, 32'hDA3B_FFE0);

    $display("[TB] asynchronous reset mid-write");
    faultMode = 0;
    applyStimulus(1'b0);
    repeat (10) @(negedge clock);
    checkOutput("pre_rst_addr", {27'd0, t_ctrl_writeReg}, 32'd10);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_test", {31'd0, test}, 32'd0);
    checkOutput("arst_we", {31'd0, t_ctrl_writeEnable}, 32'd0);
    checkOutput("arst_wr_addr", {27'd0, t_ctrl_writeReg}, 32'd0);
    checkOutput("arst_wr_data", t_data_writeReg, 32'd0);
    checkOutput("arst_fail_reg", {27'd0, fail_reg}, 32'd0);
    checkOutput("arst_fail_data", fail_data, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b0);
    waitDone(0, cyc);
    checkOutput("post_rst_latency", cyc, 32'd130);
    checkOutput("post_rst_pass", {31'd0, pass}, 32'd1);

    $display("[TB] start held high");
    applyStimulus(1'b1);
    waitDone(0, cyc);
    checkOutput("hold_latency", cyc, 32'd130);
    checkOutput("hold_pass", {31'd0, pass}, 32'd1);
    @(negedge clock);
    checkOutput("hold_restart_done", {31'd0, done}, 32'd0);
    checkOutput("hold_restart_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    waitDone(0, cyc);
    checkOutput("hold_second_latency", cyc, 32'd130);
    checkOutput("hold_second_pass", {31'd0, pass}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_bist_driver.md
Name: regfile_bist_driver

Overview:
- Built-in self-test sequencer for the register file. It sits directly upstream of the processor test wrapper.
- Drives the wrapper's test-select and `t_ctrl_*` / `t_data_writeReg` inputs.
- Consumes `t_data_readRegA` / `t_data_readRegB`.
- Runs a two-pass write/readback march over all 32 registers and reports pass/fail with the first failing register and observed value.

Parameters:
- PATTERN, 32'hA5A5_0000, base data value.
- STRIDE, 32'h0001_0001, per-register increment; raw(i) = PATTERN + i*STRIDE, mod 2^32.
- READ_LAT, 1, cycles from read-address drive to read-data valid (1..3).
- R0_ZERO, 1, when 1 register 0 is expected to read 0 regardless of the write.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin a test run; sampled only in IDLE or DONE
- test  out  1  test-mux select to wrapper; 1 while running
- t_ctrl_writeEnable  out  1  regfile write enable
- t_ctrl_writeReg  out  5  regfile write address
- t_ctrl_readRegA  out  5  port A read address
- t_ctrl_readRegB  out  5  port B read address
- t_data_writeReg  out  32  regfile write data
- t_data_readRegA  in  32  port A read data
- t_data_readRegB  in  32  port B read data
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- pass  out  1  valid when done; 1 = no mismatch
- fail_reg  out  5  first failing register
- fail_data  out  32  value observed at first failure

Behaviour:
- Clock and reset: single clock `clock`. `reset` is asynchronous, active-high; asserting it forces reset values immediately, mid-run included. No partial result is retained.
- Reset values: all outputs 0, state IDLE.
- Data per pass: d_p(i) = raw(i) for pass 0 and ~raw(i) for pass 1.
- Expected value: exp_p(i) = d_p(i), except exp_p(0) = 0 when R0_ZERO = 1.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: `start` = 1 at an edge → WRITE, pass = 0, index i = 0; `test` and `busy` go 1 the same edge.
- WRITE: t_ctrl_writeEnable = 1, t_ctrl_writeReg = i, t_data_writeReg = d_p(i).
  - i increments each cycle; 32 cycles.
  - After i = 31 → READ with k = 0; writeEnable drops to 0.
- READ: t_ctrl_readRegA = k, t_ctrl_readRegB = 31 − k, one issue per cycle for 32 cycles, then → DRAIN.
  - Expected values and addresses are delayed READ_LAT cycles in a shift pipeline aligned with returned data.
  - Every aligned cycle compares A data against exp_p(k) and B data against exp_p(31 − k).
- DRAIN: READ_LAT cycles completing outstanding compares.
  - Then pass 0 → WRITE for pass 1 (i = 0).
  - Pass 1 → DONE with pass = 1.
- Mismatch, in any READ or DRAIN compare cycle:
  - The next edge goes to DONE with pass = 0.
  - fail_reg and fail_data capture the failing register number and the observed data.
  - If A and B both mismatch in the same cycle, A wins.
  - The remaining pipeline is discarded.
- DONE: done = 1, busy = 0, test = 0, all `t_ctrl_*` = 0; results held.
  - `start` = 1 → clear done, pass, fail_reg and fail_data, then begin WRITE pass 0 as from IDLE.
- `start` is ignored while busy; holding it high during a run has no effect, and it is re-sampled only in DONE.
- Clean-run latency: 2 × (64 + READ_LAT) cycles from the start edge to done = 1.
- Addresses are 5-bit; k and i never exceed 31; no wrap beyond 31.

Test Plan:
- Good behavioural regfile model (READ_LAT = 1), defaults, 1-cycle start pulse.
  - Write cycle i = 5 drives addr 5, data 32'hA5AA_0005.
  - done = 1, pass = 1 exactly 130 cycles after the start edge; test = 0 afterwards.
- Model with reg 7 bit 0 stuck-at-0.
  - First failure at pass-0 READ k = 7, port A.
  - fail_reg = 7, fail_data = 32'hA5AC_0006, pass = 0.
- Model with writable r0 (no hardwiring).
  - fail_reg = 0, fail_data = 32'hA5A5_0000 at the first compare of pass 0.
- Model with reg 31 bit 31 stuck-at-1.
  - Pass 0 clean.
  - Pass 1 fails at k = 0 on port B: fail_reg = 31, fail_data = 32'hDA3B_FFE0 (expected 32'h5A3B_FFE0).
- Assert `reset` asynchronously mid-WRITE at i = 10.
  - All outputs 0 before the next edge; state IDLE.
  - A new start then completes with pass = 1 in 130 cycles.
- Hold `start` high for the whole run.
  - No restart while busy.
  - On reaching DONE, the still-high start restarts on the next edge: done clears and a second full run completes.
